// File: rtl/regfile_pkg.sv
// Shared definitions for the multi-port register file.
// Contents:
//   DEF_DW, DEF_NREG, DEF_CNT_W - default data width, register count and pending-counter width
//   cnt_t                       - pending counter type at the default width
//   rst_val(i)                  - reset contents of register i (its own index)
//   addr_ok(a, n)               - address a is below register count n (non power-of-two builds)
package regfile_pkg;

    localparam int DEF_DW    = 32;
    localparam int DEF_NREG  = 16;
    localparam int DEF_CNT_W = 2;

    typedef logic [DEF_CNT_W-1:0] cnt_t;

    // Each register comes out of reset holding its own index; callers cast to DW.
    function automatic logic [31:0] rst_val(int unsigned i);
        return i;
    endfunction

    function automatic logic addr_ok(int unsigned a, int unsigned n);
        return a < n;
    endfunction

endpackage

// File: rtl/register_file_mp_if.sv
// Bus bundle between ID/WB and the multi-port register file.
// Signals:
//   rd_addr/rd_data/rd_busy         - NUM_RD packed read ports (port k at [k*W +: W])
//   wb0_en/wb0_dest/wb0_data        - main writeback port
//   wb1_en/wb1_dest/wb1_data        - load/store base-update writeback port
//   issue_en/issue_dest/issue_stall - scoreboard issue request and refusal
//   sb_underflow                    - sticky scoreboard underflow flag
// Modports: master (pipeline side), slave (register file side).
interface register_file_mp_if
    import regfile_pkg::*;
#(
    parameter int DW     = DEF_DW,
    parameter int NREG   = DEF_NREG,
    parameter int AW     = $clog2(NREG),
    parameter int NUM_RD = 3
);
    logic [NUM_RD*AW-1:0] rd_addr;
    logic [NUM_RD*DW-1:0] rd_data;
    logic [NUM_RD-1:0]    rd_busy;
    logic                 wb0_en;
    logic [AW-1:0]        wb0_dest;
    logic [DW-1:0]        wb0_data;
    logic                 wb1_en;
    logic [AW-1:0]        wb1_dest;
    logic [DW-1:0]        wb1_data;
    logic                 issue_en;
    logic [AW-1:0]        issue_dest;
    logic                 issue_stall;
    logic                 sb_underflow;

    modport master (
        output rd_addr, wb0_en, wb0_dest, wb0_data, wb1_en, wb1_dest, wb1_data,
               issue_en, issue_dest,
        input  rd_data, rd_busy, issue_stall, sb_underflow
    );

    modport slave (
        input  rd_addr, wb0_en, wb0_dest, wb0_data, wb1_en, wb1_dest, wb1_data,
               issue_en, issue_dest,
        output rd_data, rd_busy, issue_stall, sb_underflow
    );
endinterface

// File: rtl/regfile_scoreboard.sv
// Per-register pending-writer scoreboard.
// Counts in-flight writers per register: +1 on an accepted issue, -1 per writeback port
// targeting the register, net change applied once per cycle and clamped at 0.
// Optional feature macro: REGFILE_WRITE_BYPASS_EN adds the drain output.
// Ports:
//   clk, rst                     - clock, synchronous active-high reset
//   issue_en, issue_dest         - issuing instruction's destination
//   wb0_en/wb0_dest, wb1_en/...  - writeback ports (decrement)
//   issue_stall                  - issue_dest counter is saturated; issue refused
//   sb_underflow                 - sticky: a writeback hit a register with nothing pending
//   busy                         - per-register pending count != 0
//   drain (bypass only)          - per-register: every pending writer writes back this cycle
module regfile_scoreboard
    import regfile_pkg::*;
#(
    parameter int NREG  = DEF_NREG,
    parameter int AW    = $clog2(NREG),
    parameter int CNT_W = DEF_CNT_W
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            issue_en,
    input  logic [AW-1:0]   issue_dest,
    input  logic            wb0_en,
    input  logic [AW-1:0]   wb0_dest,
    input  logic            wb1_en,
    input  logic [AW-1:0]   wb1_dest,
    output logic            issue_stall,
    output logic            sb_underflow,
`ifdef REGFILE_WRITE_BYPASS_EN
    output logic [NREG-1:0] drain,
`endif
    output logic [NREG-1:0] busy
);

    localparam int CNT_MAX = (1 << CNT_W) - 1;

    logic [CNT_W-1:0] cnt_q [NREG];
    logic [CNT_W-1:0] cnt_d [NREG];
    logic [1:0]       hits  [NREG];
    logic             underflow_q;
    logic             underflow_d;
    logic             issue_ok;
    logic             wb0_ok;
    logic             wb1_ok;

    assign wb0_ok = wb0_en && addr_ok(int'(wb0_dest), NREG);
    assign wb1_ok = wb1_en && addr_ok(int'(wb1_dest), NREG);

    // A writeback to issue_dest in the same cycle does not lift the stall: the check
    // looks only at the registered count.
    assign issue_stall = issue_en && addr_ok(int'(issue_dest), NREG) &&
                         (int'(cnt_q[issue_dest]) == CNT_MAX);
    assign issue_ok    = issue_en && !issue_stall && addr_ok(int'(issue_dest), NREG);

    always_comb begin
        int n;
        n           = 0;
        underflow_d = 1'b0;
        for (int i = 0; i < NREG; i++) begin
            hits[i] = {1'b0, wb0_ok && (int'(wb0_dest) == i)} +
                      {1'b0, wb1_ok && (int'(wb1_dest) == i)};
            n = int'(cnt_q[i]) - int'(hits[i]);
            if (issue_ok && (int'(issue_dest) == i)) begin
                n = n + 1;
            end
            // Net result below zero: clamp and flag; the data write still happens upstream.
            if (n < 0) begin
                cnt_d[i]    = '0;
                underflow_d = 1'b1;
            end else begin
                cnt_d[i] = CNT_W'(n);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NREG; i++) begin
                cnt_q[i] <= '0;
            end
            underflow_q <= 1'b0;
        end else begin
            for (int i = 0; i < NREG; i++) begin
                cnt_q[i] <= cnt_d[i];
            end
            underflow_q <= underflow_q | underflow_d;
        end
    end

    always_comb begin
        for (int i = 0; i < NREG; i++) begin
            busy[i] = (cnt_q[i] != '0);
        end
    end

`ifdef REGFILE_WRITE_BYPASS_EN
    always_comb begin
        for (int i = 0; i < NREG; i++) begin
            drain[i] = (cnt_q[i] != '0) && (int'(cnt_q[i]) == int'(hits[i]));
        end
    end
`endif

    assign sb_underflow = underflow_q;

endmodule

// File: rtl/register_file_mp.sv
// Multi-port register file: NUM_RD combinational read ports, two synchronous writeback
// ports (WB0 wins on address collision) and a pending-writer scoreboard.
// Optional feature macro: REGFILE_WRITE_BYPASS_EN - read ports forward same-cycle
// writeback data and hide busy when the forwarded write drains the register.
// Ports:
//   clk  - clock, all state on posedge
//   rst  - synchronous active-high reset; registers reload their index, scoreboard clears
//   bus  - register_file_mp_if.slave bundle (reads, writebacks, issue, status)
module register_file_mp
    import regfile_pkg::*;
#(
    parameter int DW     = DEF_DW,
    parameter int NREG   = DEF_NREG,
    parameter int AW     = $clog2(NREG),
    parameter int NUM_RD = 3,
    parameter int CNT_W  = DEF_CNT_W
) (
    input logic               clk,
    input logic               rst,
    register_file_mp_if.slave bus
);

    logic [DW-1:0]   data_q [NREG];
    logic [NREG-1:0] busy;
`ifdef REGFILE_WRITE_BYPASS_EN
    logic [NREG-1:0] drain;
`endif

    regfile_scoreboard #(
        .NREG  (NREG),
        .AW    (AW),
        .CNT_W (CNT_W)
    ) u_scoreboard (
        .clk          (clk),
        .rst          (rst),
        .issue_en     (bus.issue_en),
        .issue_dest   (bus.issue_dest),
        .wb0_en       (bus.wb0_en),
        .wb0_dest     (bus.wb0_dest),
        .wb1_en       (bus.wb1_en),
        .wb1_dest     (bus.wb1_dest),
        .issue_stall  (bus.issue_stall),
        .sb_underflow (bus.sb_underflow),
`ifdef REGFILE_WRITE_BYPASS_EN
        .drain        (drain),
`endif
        .busy         (busy)
    );

    // WB1 is applied first so a WB0 write to the same register overrides it.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NREG; i++) begin
                data_q[i] <= DW'(rst_val(i));
            end
        end else begin
            if (bus.wb1_en && addr_ok(int'(bus.wb1_dest), NREG)) begin
                data_q[bus.wb1_dest] <= bus.wb1_data;
            end
            if (bus.wb0_en && addr_ok(int'(bus.wb0_dest), NREG)) begin
                data_q[bus.wb0_dest] <= bus.wb0_data;
            end
        end
    end

    always_comb begin
        logic [AW-1:0] a;
        logic          ok;
        a           = '0;
        ok          = 1'b0;
        bus.rd_data = '0;
        bus.rd_busy = '0;
        for (int k = 0; k < NUM_RD; k++) begin
            a  = bus.rd_addr[k*AW +: AW];
            ok = addr_ok(int'(a), NREG);
            if (ok) begin
`ifdef REGFILE_WRITE_BYPASS_EN
                if (bus.wb0_en && (bus.wb0_dest == a)) begin
                    bus.rd_data[k*DW +: DW] = bus.wb0_data;
                end else if (bus.wb1_en && (bus.wb1_dest == a)) begin
                    bus.rd_data[k*DW +: DW] = bus.wb1_data;
                end else begin
                    bus.rd_data[k*DW +: DW] = data_q[a];
                end
                bus.rd_busy[k] = busy[a] && !drain[a];
`else
                bus.rd_data[k*DW +: DW] = data_q[a];
                bus.rd_busy[k]          = busy[a];
`endif
            end
        end
    end

endmodule

// File: doc/register_file_mp.md
Name: register_file_mp

Overview:
- Parametrised successor to the ARM core's 16x32 register file.
- Provides NUM_RD combinational read ports and two synchronous write ports:
  - WB0: main writeback stage.
  - WB1: load/store base-update writeback.
- Includes a per-register pending-write scoreboard that counts in-flight writers and flags read hazards to the hazard unit.
- Sits between ID (reads, issue) and WB (writes).

Parameters:
- DW, 32, data width in bits.
- NREG, 16, number of architectural registers (power of two, >= 2).
- AW, $clog2(NREG), register address width.
- NUM_RD, 3, number of read ports (1..4).
- CNT_W, 2, width of per-register pending counter; max in-flight writers = 2^CNT_W - 1.

Ports:
- clk  in  1  clock; all state updates on posedge.
- rst  in  1  reset, synchronous, active-high.
- rd_addr  in  NUM_RD*AW  read addresses; port k occupies bits [k*AW +: AW].
- rd_data  out  NUM_RD*DW  read data; port k occupies bits [k*DW +: DW].
- rd_busy  out  NUM_RD  port k's register has pending count != 0.
- wb0_en  in  1  write enable, port 0.
- wb0_dest  in  AW  write address, port 0.
- wb0_data  in  DW  write data, port 0.
- wb1_en  in  1  write enable, port 1.
- wb1_dest  in  AW  write address, port 1.
- wb1_data  in  DW  write data, port 1.
- issue_en  in  1  instruction with destination issues this cycle.
- issue_dest  in  AW  destination register of issuing instruction.
- issue_stall  out  1  issue_dest counter saturated; issue is refused.
- sb_underflow  out  1  sticky error flag, set on writeback to a non-pending register.

Behaviour:
- Reset (rst=1 at posedge):
  - data[i] <= i, zero-extended or truncated to DW.
  - All pending counters <= 0.
  - sb_underflow <= 0.
  - All writes and issues in that cycle are ignored.
  - After reset: rd_data shows the index value, rd_busy=0, issue_stall=0.
- Reads:
  - Combinational: rd_data[k] = data[rd_addr[k]].
  - Without bypass, a write becomes visible the cycle after its posedge.
- Writes:
  - Committed at posedge when the enable is high.
  - Both ports to the same address: WB0 data wins. Both counter decrements still apply.
  - Different addresses: both commit in the same cycle.
- Scoreboard (one counter per register):
  - issue_en && !issue_stall: increment cnt[issue_dest].
  - Each writeback enable: decrement cnt[dest].
  - Net change per register per cycle = (+1 accepted issue) - (number of write ports targeting it). Range is -2..+1, applied once.
  - Simultaneous issue and a single writeback to the same register: counter unchanged.
  - A decrement that would go below 0 clamps at 0 and sets sb_underflow. The data write still happens.
  - sb_underflow clears only on rst.
- issue_stall:
  - Combinational: issue_en && cnt[issue_dest] == 2^CNT_W-1.
  - A writeback to issue_dest in the same cycle does not lift the stall.
  - A stalled issue changes no state.
- rd_busy[k]:
  - Combinational: cnt[rd_addr[k]] != 0, from registered counters.
  - Same-cycle issues or writebacks are not reflected until the next cycle.
- Address width:
  - All addresses are exactly AW bits.
  - If NREG is not a power of two, an out-of-range read returns 0 and an out-of-range write or issue is ignored.

Optional Feature:
- Macro: REGFILE_WRITE_BYPASS_EN.
- Defined: each read port forwards same-cycle write data combinationally.
  - If wb0_en && wb0_dest == rd_addr[k], return wb0_data.
  - Else if wb1_en && wb1_dest == rd_addr[k], return wb1_data.
  - Else return the array value.
  - rd_busy[k] is forced to 0 when the forwarded writeback is the register's last pending writer, i.e. cnt - hits == 0 and cnt != 0.
- Undefined: plain array read with one-cycle write visibility, as described above.

Decomposition:
- Package regfile_pkg holds:
  - Default DW, NREG, CNT_W localparams.
  - Reset-value function rst_val(i).
  - Typedef for counter type.
- One natural sub-module, regfile_scoreboard:
  - Holds the counters and the underflow flag.
  - Drives issue_stall and a per-register busy vector.
  - The top level indexes the busy vector per read port and holds the data array and bypass muxes.

Test Plan:
- Reset then read regs 0, 5, 15 -> rd_data = 0x0, 0x5, 0xF; rd_busy=0, issue_stall=0, sb_underflow=0.
- WB0 writes r3=0xDEADBEEF and WB1 writes r7=0x12345678 in the same cycle -> next cycle r3 and r7 read back those values.
- Same cycle, both ports write r4 (0xAAAA0000 vs 0x5555FFFF) -> r4=0xAAAA0000.
- Issue r2 three times (CNT_W=2) -> rd_busy set after the first issue; 4th issue gives issue_stall=1 and count stays 3. Three WB0 writes to r2 -> rd_busy clears the cycle after the third write.
- With cnt[r9]=1, issue r9 and WB0 r9 in the same cycle -> count stays 1 and rd_busy stays 1. Then WB0 r9 twice -> first write clears the count; second sets sb_underflow=1, which holds until rst.
- With REGFILE_WRITE_BYPASS_EN, read r6 while WB1 writes r6=0x0BADF00D -> same-cycle rd_data=0x0BADF00D; without the macro the old value shows and the new one appears the next cycle.
